dot_product_mac: RTL and testbench

- Sequencing and accumulation stage that feeds operand pairs to the team's 8x8 sequential shift-add multiplier and consumes its 16-bit products.
- Accepts a stream of (a, b) pairs on a valid/ready handshake and issues one multiply at a time over a start/done interface.
- Sums the products into an accumulator and presents the completed dot product on an output valid/ready handshake when the pair tagged `last` has been accumulated.

---
 rtl/dot_product_mac.sv | 137 +++++++++++++
 tb/tb_dot_product_mac.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_mac.sv
// Dot-product sequencer: feeds operand pairs one at a time to an external
// 8x8 multiplier, sums the products and hands back the finished result.
module dot_product_mac #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic             mul_start,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic             mul_done,
  input  logic [15:0]      mul_product,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_ovf,
  output logic [CNT_W-1:0] term_cnt
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ISSUE  = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] ACCUM  = 3'd3;
  localparam logic [2:0] OUTPUT = 3'd4;

  logic [2:0]       state_q, state_d;
  logic             ready_q, ready_d;
  logic             start_q, start_d;
  logic             valid_q, valid_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic             last_q, last_d;
  logic [15:0]      prod_q, prod_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W:0]   sum;

  // The extra top bit of the sum is the carry that sets the sticky wrap flag.
  assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - 16){1'b0}}, prod_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    last_d  = last_q;
    prod_d  = prod_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid && ready_q) begin
          last_d = in_last;
          // A zero operand makes the product trivially zero, so skip the multiplier.
          if (in_a == 8'd0 || in_b == 8'd0) begin
            prod_d  = 16'd0;
            state_d = ACCUM;
          end else begin
            a_d     = in_a;
            b_d     = in_b;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mul_done) begin
          prod_d  = mul_product;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = sum[ACC_W-1:0];
        if (sum[ACC_W]) ovf_d = 1'b1;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        state_d = last_q ? OUTPUT : IDLE;
      end
      OUTPUT: begin
        if (acc_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    start_d = (state_d == ISSUE);
    valid_d = (state_d == OUTPUT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      last_q  <= 1'b0;
      prod_q  <= 16'd0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      start_q <= start_d;
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      last_q  <= last_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = ready_q;
  assign mul_start = start_q;
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign acc_valid = valid_q;
  assign acc_out   = acc_q;
  assign acc_ovf   = ovf_q;
  assign term_cnt  = cnt_q;

endmodule

// File: tb/tb_dot_product_mac.sv
// Bench for dot_product_mac: a 24-bit and a 16-bit accumulator instance share
// the input stream; results are compared against a plain arithmetic sum.
module tb_dot_product_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inValid = 1'b0;
  logic [7:0]  inA = 8'd0;
  logic [7:0]  inB = 8'd0;
  logic        inLast = 1'b0;
  logic        accReady = 1'b0;

  logic        inReadyW, mulStartW, accValidW, accOvfW;
  logic [7:0]  mulAW, mulBW, termCntW;
  logic        mulDoneW = 1'b0;
  logic [15:0] mulProdW = 16'd0;
  logic [23:0] accOutW;

  logic        inReadyN, mulStartN, accValidN, accOvfN;
  logic [7:0]  mulAN, mulBN, termCntN;
  logic        mulDoneN = 1'b0;
  logic [15:0] mulProdN = 16'd0;
  logic [15:0] accOutN;

  int testCount = 0;
  int failCount = 0;
  int startCount = 0;
  int mulLat = 16;
  logic [7:0] vecA[$];
  logic [7:0] vecB[$];

  always #5 clk = ~clk;

  dot_product_mac #(.ACC_W(24), .CNT_W(8)) dutW (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReadyW),
    .in_a(inA), .in_b(inB), .in_last(inLast),
    .mul_start(mulStartW), .mul_a(mulAW), .mul_b(mulBW),
    .mul_done(mulDoneW), .mul_product(mulProdW),
    .acc_valid(accValidW), .acc_ready(accReady), .acc_out(accOutW),
    .acc_ovf(accOvfW), .term_cnt(termCntW)
  );

  dot_product_mac #(.ACC_W(16), .CNT_W(8)) dutN (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReadyN),
    .in_a(inA), .in_b(inB), .in_last(inLast),
    .mul_start(mulStartN), .mul_a(mulAN), .mul_b(mulBN),
    .mul_done(mulDoneN), .mul_product(mulProdN),
    .acc_valid(accValidN), .acc_ready(accReady), .acc_out(accOutN),
    .acc_ovf(accOvfN), .term_cnt(termCntN)
  );

  // Behavioural multipliers: result appears mulLat cycles after the start pulse.
  bit busyW = 1'b0, busyN = 1'b0;
  int remW = 0, remN = 0;
  always @(posedge clk) begin
    mulDoneW <= 1'b0;
    if (mulStartW === 1'b1) begin
      busyW <= 1'b1; remW <= mulLat; mulProdW <= mulAW * mulBW;
    end else if (busyW) begin
      if (remW <= 1) begin busyW <= 1'b0; mulDoneW <= 1'b1; end
      else remW <= remW - 1;
    end
  end
  always @(posedge clk) begin
    mulDoneN <= 1'b0;
    if (mulStartN === 1'b1) begin
      busyN <= 1'b1; remN <= mulLat; mulProdN <= mulAN * mulBN;
    end else if (busyN) begin
      if (remN <= 1) begin busyN <= 1'b0; mulDoneN <= 1'b1; end
      else remN <= remN - 1;
    end
  end

  always @(posedge clk) if (mulStartW === 1'b1) startCount++;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sendPair(input logic [7:0] a, input logic [7:0] b, input logic last);
    int waited = 0;
    @(negedge clk);
    while (inReadyW !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) checkOutput("accept_timeout", inReadyW, 1);
    inValid = 1'b1; inA = a; inB = b; inLast = last;
    @(posedge clk);
    #1 inValid = 1'b0;
  endtask

  // Streams the queued pairs, then checks the result against the true sum.
  task automatic applyStimulus(input string tag, input int holdCycles);
    longint total = 0;
    int n = vecA.size();
    int issues = 0;
    int startsBefore = startCount;
    int waited = 0;
    logic [63:0] expW, expN, expCnt;
    for (int i = 0; i < n; i++) begin
      sendPair(vecA[i], vecB[i], i == n - 1);
      total += longint'(vecA[i]) * longint'(vecB[i]);
      if (vecA[i] != 0 && vecB[i] != 0) issues++;
    end
    while (accValidW !== 1'b1 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, "_valid"}, accValidW, 1);
    expW   = total & 64'hFF_FFFF;
    expN   = total & 64'hFFFF;
    expCnt = (n > 255) ? 255 : n;
    checkOutput({tag, "_starts"}, startCount - startsBefore, issues);
    checkOutput({tag, "_accW"}, accOutW, expW);
    checkOutput({tag, "_ovfW"}, accOvfW, total >= 64'd16777216);
    checkOutput({tag, "_cntW"}, termCntW, expCnt);
    checkOutput({tag, "_accN"}, accOutN, expN);
    checkOutput({tag, "_ovfN"}, accOvfN, total >= 64'd65536);
    checkOutput({tag, "_cntN"}, termCntN, expCnt);
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      checkOutput({tag, "_holdValid"}, accValidW, 1);
      checkOutput({tag, "_holdAcc"}, accOutW, expW);
      checkOutput({tag, "_holdReady"}, inReadyW, 0);
    end
    @(negedge clk);
    accReady = 1'b1;
    @(posedge clk);
    #1 accReady = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_relValid"}, accValidW, 0);
    checkOutput({tag, "_relAcc"}, accOutW, 0);
    checkOutput({tag, "_relOvf"}, accOvfN, 0);
    checkOutput({tag, "_relCnt"}, termCntW, 0);
    checkOutput({tag, "_relReady"}, inReadyW, 1);
  endtask

  task automatic loadVec(input logic [7:0] a, input logic [7:0] b);
    vecA.push_back(a);
    vecB.push_back(b);
  endtask

  initial begin
    // Reset held with a pending pair: nothing may be accepted or issued.
    rst = 1'b0; inValid = 1'b1; inA = 8'd3; inB = 8'd4; inLast = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_ready", inReadyW, 0);
      checkOutput("rst_start", mulStartW, 0);
      checkOutput("rst_valid", accValidW, 0);
      checkOutput("rst_acc", accOutW, 0);
      checkOutput("rst_cnt", termCntW, 0);
      checkOutput("rst_ovf", accOvfW, 0);
    end
    rst = 1'b1; inValid = 1'b0;
    @(negedge clk);
    checkOutput("rst_releaseReady", inReadyW, 1);

    mulLat = 16;
    vecA = {}; vecB = {};
    loadVec(3, 4); loadVec(5, 6); loadVec(255, 255);
    applyStimulus("dot", 10);

    vecA = {}; vecB = {};
    loadVec(0, 200); loadVec(7, 0); loadVec(2, 9);
    applyStimulus("zero", 0);

    mulLat = 3;
    vecA = {}; vecB = {};
    loadVec(255, 255); loadVec(1, 2);
    applyStimulus("noWrap", 1);
    vecA = {}; vecB = {};
    loadVec(255, 255); loadVec(255, 255);
    applyStimulus("wrap", 2);
    vecA = {}; vecB = {};
    loadVec(255, 255); loadVec(255, 255); loadVec(1, 1);
    applyStimulus("sticky", 0);

    vecA = {}; vecB = {};
    loadVec(9, 0);
    applyStimulus("single", 0);

    // Term counter must saturate rather than wrap.
    vecA = {}; vecB = {};
    for (int i = 0; i < 299; i++) loadVec(8'd0, 8'(i));
    loadVec(1, 1);
    applyStimulus("sat", 0);

    for (int v = 0; v < 6; v++) begin
      int len = $urandom_range(1, 5);
      mulLat = $urandom_range(1, 6);
      vecA = {}; vecB = {};
      for (int i = 0; i < len; i++) begin
        logic [7:0] ra, rb;
        ra = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
        rb = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
        loadVec(ra, rb);
      end
      applyStimulus("rand", $urandom_range(0, 3));
    end

    // Reset while waiting on the multiplier; its late done must be ignored.
    mulLat = 16;
    sendPair(9, 9, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midRst_valid", accValidW, 0);
    rst = 1'b1;
    repeat (25) @(negedge clk);
    checkOutput("midRst_acc", accOutW, 0);
    checkOutput("midRst_cnt", termCntW, 0);
    checkOutput("midRst_valid2", accValidW, 0);
    checkOutput("midRst_ready", inReadyW, 1);
    mulLat = 2;
    vecA = {}; vecB = {};
    loadVec(2, 3);
    applyStimulus("postRst", 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
